// File: rtl/code_rom_loader.sv
// code_rom_loader: framed byte-stream loader for the debug harness code ROM.
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CHK (XOR of payload).
// Each accepted payload byte k is presented as one ROM write (addr k, data byte).
// Optional feature macro: CODE_ROM_LOADER_KILL_PAD_EN. When it is defined, a good
// frame is followed by four 0xFF bytes (end meta-instruction) at addresses LEN..LEN+3.
module code_rom_loader #(
    parameter int          ROM_BYTES = 68,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        hclk,
    input  logic        reset_code_rom_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        program_rom_mode,
    output logic [11:0] code_rom_addr_in,
    output logic [7:0]  code_rom_data_in,
    output logic        load_done,
    output logic        load_error,
    output logic [11:0] load_len
);

`ifdef CODE_ROM_LOADER_KILL_PAD_EN
    // Four bytes of ROM are reserved for the appended end meta-instruction.
    localparam int LEN_MAX = ROM_BYTES - 4;
`else
    localparam int LEN_MAX = ROM_BYTES;
`endif
    localparam logic [11:0] LEN_MAX_W = 12'(LEN_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
        S_CHK    = 3'd4,
        S_PAD    = 3'd5
`else
        S_CHK    = 3'd4
`endif
    } state_t;

    state_t      state_q;
    logic [7:0]  len_lo_q;
    logic [11:0] load_len_q;
    logic [11:0] byte_cnt_q;
    logic [7:0]  xor_q;
    logic        prog_q;
    logic [11:0] addr_q;
    logic [7:0]  data_q;
    logic        done_q;
    logic        error_q;
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
    logic [1:0]  pad_cnt_q;
`endif

    logic        xfer;
    logic [11:0] len_w;
    logic        len_ok;

    // Host can push a byte in every state except while the kill pad is written.
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
    assign in_ready = (state_q != S_PAD);
`else
    assign in_ready = 1'b1;
`endif

    assign xfer   = in_valid && in_ready;
    assign len_w  = {in_data[3:0], len_lo_q};
    assign len_ok = (in_data[7:4] == 4'h0) && (len_w != 12'd0) && (len_w <= LEN_MAX_W);

    assign program_rom_mode = prog_q;
    assign code_rom_addr_in = addr_q;
    assign code_rom_data_in = data_q;
    assign load_done        = done_q;
    assign load_error       = error_q;
    assign load_len         = load_len_q;

    // Frame parser FSM with registered ROM-write and status outputs.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            load_len_q <= '0;
            byte_cnt_q <= '0;
            xor_q      <= '0;
            prog_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
            pad_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        xor_q   <= '0;
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo_q <= in_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        if (len_ok) begin
                            load_len_q <= len_w;
                            byte_cnt_q <= '0;
                            state_q    <= S_DATA;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    // Write enable stays high between bytes; addr/data simply hold.
                    if (xfer) begin
                        prog_q     <= 1'b1;
                        addr_q     <= byte_cnt_q;
                        data_q     <= in_data;
                        xor_q      <= xor_q ^ in_data;
                        byte_cnt_q <= byte_cnt_q + 12'd1;
                        if (byte_cnt_q == load_len_q - 12'd1) begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        if (in_data == xor_q) begin
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
                            // First pad write issues on the CHK edge so the
                            // write enable stays high without a bubble.
                            addr_q    <= load_len_q;
                            data_q    <= 8'hFF;
                            pad_cnt_q <= 2'd1;
                            state_q   <= S_PAD;
`else
                            prog_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
`endif
                        end else begin
                            prog_q  <= 1'b0;
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef CODE_ROM_LOADER_KILL_PAD_EN
                S_PAD: begin
                    // pad_cnt_q wraps 3 -> 0 after the fourth write has been shown.
                    if (pad_cnt_q == 2'd0) begin
                        prog_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        addr_q    <= load_len_q + {10'd0, pad_cnt_q};
                        data_q    <= 8'hFF;
                        pad_cnt_q <= pad_cnt_q + 2'd1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
